// File: rtl/priority_scan_display_if.sv
// Pin-side bundle for priority_scan_display: request/mode/hold in, display and status out.
interface priority_scan_display_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             lsb_mode;
  logic             hold;
  logic [6:0]       segments;
  logic             none;
  logic [1:0]       digit_sel;
  logic [3:0]       index;
  logic             changed;

  modport master (
    output data, lsb_mode, hold,
    input  segments, none, digit_sel, index, changed
  );

  modport slave (
    input  data, lsb_mode, hold,
    output segments, none, digit_sel, index, changed
  );
endinterface

// File: rtl/priority_scan_display.sv
// Priority encoder driving a two-digit multiplexed 7-segment display; index/changed 2 edges after input, segments/none 3.
// Free-running, no backpressure: inputs sampled every cycle, hold only freezes the encoded result.
module priority_scan_display #(
  parameter int WIDTH = 16,
  parameter int DWELL = 1024
) (
  input logic                  clk,
  input logic                  rst,
  priority_scan_display_if.slave bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [WIDTH-1:0] data_q;
  logic             mode_q;
  logic [3:0]       index_q;
  logic             none_q;
  logic             changed_q;
  logic [CW-1:0]    scan_cnt;
  logic [1:0]       digit_sel_q;
  logic [6:0]       seg_q;
  logic             none_disp_q;

  logic [3:0]       win_idx;
  logic             win_none;
  logic [1:0]       sel_next;
  logic [3:0]       units_val;
  logic [6:0]       units_seg;
  logic [6:0]       tens_seg;
  logic [6:0]       seg_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      mode_q <= 1'b0;
    end else begin
      data_q <= bus.data;
      mode_q <= bus.lsb_mode;
    end
  end

  // The last set bit visited wins, so the scan direction picks the priority.
  always_comb begin
    win_idx  = 4'd0;
    win_none = (data_q == '0);
    if (mode_q) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (data_q[i]) win_idx = 4'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (data_q[i]) win_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q   <= 4'd0;
      none_q    <= 1'b1;
      changed_q <= 1'b0;
    end else if (!bus.hold) begin
      index_q   <= win_idx;
      none_q    <= win_none;
      changed_q <= ({win_idx, win_none} != {index_q, none_q});
    end else begin
      changed_q <= 1'b0;
    end
  end

  assign sel_next = (scan_cnt == LAST) ? {digit_sel_q[0], digit_sel_q[1]} : digit_sel_q;

  always_comb begin
    units_val = (index_q >= 4'd10) ? index_q - 4'd10 : index_q;
    case (units_val)
      4'd0:    units_seg = 7'b0111111;
      4'd1:    units_seg = 7'b0000110;
      4'd2:    units_seg = 7'b1011011;
      4'd3:    units_seg = 7'b1001111;
      4'd4:    units_seg = 7'b1100110;
      4'd5:    units_seg = 7'b1101101;
      4'd6:    units_seg = 7'b1111101;
      4'd7:    units_seg = 7'b0000111;
      4'd8:    units_seg = 7'b1111111;
      4'd9:    units_seg = 7'b1101111;
      default: units_seg = 7'b0000000;
    endcase
    tens_seg = (index_q >= 4'd10) ? 7'b0000110 : 7'b0000000;
    if (none_q)           seg_next = 7'b0000000;
    else if (sel_next[1]) seg_next = tens_seg;
    else                  seg_next = units_seg;
  end

  // Segments are loaded for the digit selected on the same edge so the pair never disagrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      digit_sel_q <= 2'b01;
      seg_q       <= 7'b0000000;
      none_disp_q <= 1'b1;
    end else begin
      scan_cnt    <= (scan_cnt == LAST) ? '0 : scan_cnt + CW'(1);
      digit_sel_q <= sel_next;
      seg_q       <= seg_next;
      none_disp_q <= none_q;
    end
  end

  assign bus.segments  = seg_q;
  assign bus.none      = none_disp_q;
  assign bus.digit_sel = digit_sel_q;
  assign bus.index     = index_q;
  assign bus.changed   = changed_q;

endmodule

// File: tb/tb_priority_scan_display.sv
// Bench for priority_scan_display: 16-bit and 8-bit instances against a queue-based reference model.
module tb_priority_scan_display;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        mode;
  logic        hold_in;

  always #5 clk = ~clk;

  priority_scan_display_if #(.WIDTH(16)) b16 ();
  priority_scan_display_if #(.WIDTH(8))  b8 ();

  assign b16.data     = din;
  assign b16.lsb_mode = mode;
  assign b16.hold     = hold_in;
  assign b8.data      = din[7:0];
  assign b8.lsb_mode  = mode;
  assign b8.hold      = hold_in;

  priority_scan_display #(.WIDTH(16), .DWELL(DW)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
  priority_scan_display #(.WIDTH(8),  .DWELL(DW)) u8  (.clk(clk), .rst(rst), .bus(b8.slave));

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] glyph [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  int         lane_w [2] = '{16, 8};

  int         m_idx [2];
  bit         m_none [2];
  bit         m_chg [2];
  logic [6:0] m_seg [2];
  bit         m_ndisp [2];
  bit [15:0]  m_dq;
  bit         m_mq;
  int         m_cyc;
  logic [1:0] exp_sel;

  function automatic void ref_win(input bit [15:0] d, input bit lsb, input int w,
                                  output int idx, output bit nn);
    int q[$];
    for (int i = 0; i < w; i++) if (d[i]) q.push_back(i);
    nn  = (q.size() == 0);
    idx = nn ? 0 : (lsb ? q[0] : q[$]);
  endfunction

  function automatic logic [6:0] shown(input int idx, input bit nn, input bit tens);
    if (nn)   return 7'b0000000;
    if (tens) return (idx >= 10) ? 7'b0000110 : 7'b0000000;
    return glyph[idx % 10];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    int ni;
    bit nn;
    @(posedge clk);
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        m_idx[l] = 0; m_none[l] = 1; m_chg[l] = 0; m_seg[l] = 7'b0; m_ndisp[l] = 1;
      end
      m_dq = '0; m_mq = 0; m_cyc = 0;
    end else begin
      m_cyc++;
      exp_sel = ((m_cyc / DW) % 2 == 1) ? 2'b10 : 2'b01;
      for (int l = 0; l < 2; l++) begin
        m_seg[l]   = shown(m_idx[l], m_none[l], exp_sel[1]);
        m_ndisp[l] = m_none[l];
        if (!hold_in) begin
          ref_win(m_dq, m_mq, lane_w[l], ni, nn);
          m_chg[l]  = (ni != m_idx[l]) || (nn != m_none[l]);
          m_idx[l]  = ni;
          m_none[l] = nn;
        end else begin
          m_chg[l] = 0;
        end
      end
      m_dq = din;
      m_mq = mode;
    end
    exp_sel = ((m_cyc / DW) % 2 == 1) ? 2'b10 : 2'b01;
    #1;
    check("w16 index",     16'(b16.index),     16'(m_idx[0]));
    check("w16 changed",   16'(b16.changed),   16'(m_chg[0]));
    check("w16 digit_sel", 16'(b16.digit_sel), 16'(exp_sel));
    check("w16 segments",  16'(b16.segments),  16'(m_seg[0]));
    check("w16 none",      16'(b16.none),      16'(m_ndisp[0]));
    check("w8 index",      16'(b8.index),      16'(m_idx[1]));
    check("w8 changed",    16'(b8.changed),    16'(m_chg[1]));
    check("w8 segments",   16'(b8.segments),   16'(m_seg[1]));
    check("w8 none",       16'(b8.none),       16'(m_ndisp[1]));
    if (exp_sel == 2'b10) check("w8 tens blank", 16'(b8.segments), 16'h0);
  endtask

  initial begin
    rst = 1'b1; din = '0; mode = 1'b0; hold_in = 1'b0;
    repeat (3) step();
    check("reset index",     16'(b16.index),     16'd0);
    check("reset none",      16'(b16.none),      16'd1);
    check("reset segments",  16'(b16.segments),  16'd0);
    check("reset digit_sel", 16'(b16.digit_sel), 16'b01);

    rst = 1'b0;
    repeat (DW - 1) step();
    check("digit_sel before first toggle", 16'(b16.digit_sel), 16'b01);
    step();
    check("digit_sel first toggle", 16'(b16.digit_sel), 16'b10);
    repeat (6) step();

    din = 16'h8001; mode = 1'b0;
    repeat (2) step();
    check("msb 8001 index", 16'(b16.index), 16'd15);
    repeat (2 * DW) begin
      step();
      check("msb 8001 segs", 16'(b16.segments), (b16.digit_sel == 2'b01) ? 16'b1101101 : 16'b0000110);
      check("msb 8001 none", 16'(b16.none), 16'd0);
    end

    mode = 1'b1;
    repeat (2) step();
    check("lsb 8001 index", 16'(b16.index), 16'd0);
    repeat (2 * DW) begin
      step();
      check("lsb 8001 segs", 16'(b16.segments), (b16.digit_sel == 2'b01) ? 16'b0111111 : 16'b0000000);
    end
    din = 16'h0030;
    repeat (2) step();
    check("lsb 0030 index", 16'(b16.index), 16'd4);
    mode = 1'b0;
    repeat (2) step();
    check("msb 0030 index", 16'(b16.index), 16'd5);

    din = 16'h0200;
    repeat (3) step();
    check("pre-hold index", 16'(b16.index), 16'd9);
    hold_in = 1'b1; din = 16'h0004;
    repeat (4) begin
      step();
      check("held index",   16'(b16.index),   16'd9);
      check("held changed", 16'(b16.changed), 16'd0);
    end
    hold_in = 1'b0;
    step();
    check("release index",   16'(b16.index),   16'd2);
    check("release changed", 16'(b16.changed), 16'd1);
    step();
    check("release single pulse", 16'(b16.changed), 16'd0);

    for (int md = 0; md < 2; md++) begin
      mode = md[0];
      for (int b = 0; b < 16; b++) begin
        din = 16'd1 << b;
        repeat (2) step();
        check("walk index", 16'(b16.index), 16'(b));
      end
    end

    repeat (400) begin
      din     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) din = din & 16'($urandom);
      if ($urandom_range(0, 7) == 0) din = '0;
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      hold_in = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(1, 3)) step();
    end

    hold_in = 1'b1; din = 16'hA5A5;
    for (int k = 0; k < 2 * DW && exp_sel != 2'b10; k++) step();
    step();
    rst = 1'b1;
    step();
    check("mid reset digit_sel", 16'(b16.digit_sel), 16'b01);
    check("mid reset segments",  16'(b16.segments),  16'd0);
    check("mid reset none",      16'(b16.none),      16'd1);
    check("mid reset index",     16'(b16.index),     16'd0);
    rst = 1'b0; hold_in = 1'b0;
    repeat (DW - 1) step();
    check("scan restart hold", 16'(b16.digit_sel), 16'b01);
    step();
    check("scan restart toggle", 16'(b16.digit_sel), 16'b10);
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
